// File: rtl/pkt_chk_pkg.sv
// Shared definitions for the packet checker: error bit positions,
// channel count and FSM state encoding.
package pkt_pkg;

  localparam int ERR_MISS_EOP  = 0;
  localparam int ERR_STRAY_EOP = 1;
  localparam int ERR_OVERLEN   = 2;
  localparam int ERR_CHAN      = 3;

  localparam int NUM_CHAN = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/pkt_chk_stat_cnt.sv
// Per-channel good/bad packet counter pair. Both counters saturate at
// all-ones; a clear wins over a coincident increment.
module pkt_stat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_good_i,
  input  logic             inc_bad_i,
  output logic [CNT_W-1:0] good_o,
  output logic [CNT_W-1:0] bad_o
);

  logic [CNT_W-1:0] good_q, bad_q;

  // Counter registers: clear first, then saturating increment.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= '0;
      bad_q  <= '0;
    end else if (clr_i) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      if (inc_good_i && good_q != '1) good_q <= good_q + 1'b1;
      if (inc_bad_i  && bad_q  != '1) bad_q  <= bad_q + 1'b1;
    end
  end

  assign good_o = good_q;
  assign bad_o  = bad_q;

endmodule

// File: rtl/pkt_chk.sv
// Packet framing checker for the merged 3-channel stream. Tracks one open
// packet, reports length / modular sum / error flags one cycle after the
// terminating beat, and keeps per-channel good/bad statistics.
module pkt_chk
  import pkt_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 12,
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic              din_vld,
  input  logic [1:0]        din_chan,
  output logic              pkt_done,
  output logic [1:0]        pkt_chan,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [DATA_W-1:0] pkt_sum,
  output logic [3:0]        pkt_err,
  input  logic              stat_clr,
  input  logic [1:0]        stat_sel,
  output logic [CNT_W-1:0]  stat_good,
  output logic [CNT_W-1:0]  stat_bad
);

  typedef struct packed {
    logic              vld;
    logic [1:0]        chan;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] sum;
    logic [3:0]        err;
  } rec_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_e            state_q, state_d;
  logic [1:0]        chan_q, chan_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [3:0]        err_q, err_d;
  rec_t              pend_q, pend_d;
  rec_t              rec1, rec2, take;
  logic              done_q;
  rec_t              out_q;

  logic [LEN_W-1:0]  busy_len;
  logic [DATA_W-1:0] busy_sum;
  logic [3:0]        busy_err, open_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a non-eop sop opens a packet, any eop closes it.
  always_comb begin
    state_d = state_q;
    if (din_vld) begin
      if (din_sop && !din_eop) state_d = BUSY;
      else if (din_eop)        state_d = IDLE;
    end
  end

  // Continuation-beat values: saturating length, modular sum, sticky errors.
  always_comb begin
    busy_len = (len_q == '1) ? len_q : len_q + 1'b1;
    busy_sum = sum_q + din;
    busy_err = err_q;
    if (busy_len > MAX_LEN_L) busy_err[ERR_OVERLEN] = 1'b1;
    if (din_chan != chan_q)   busy_err[ERR_CHAN]    = 1'b1;
    open_err = '0;
    if (din_chan == 2'd3)     open_err[ERR_CHAN]    = 1'b1;
  end

  // Accumulator update and records produced by the current beat. rec2 is
  // only used when a sop&eop beat both aborts the open packet and forms a
  // complete single-beat packet of its own.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    chan_d = chan_q;
    len_d  = len_q;
    sum_d  = sum_q;
    err_d  = err_q;
    rec1   = '0;
    rec2   = '0;
    if (din_vld) begin
      if (din_sop) begin
        if (state_q == BUSY) begin
          rec1 = '{1'b1, chan_q, len_q, sum_q, err_q | 4'(1 << ERR_MISS_EOP)};
        end
        chan_d = din_chan;
        len_d  = LEN_W'(1);
        sum_d  = din;
        err_d  = open_err;
        if (din_eop) begin
          if (state_q == BUSY) rec2 = '{1'b1, din_chan, LEN_W'(1), din, open_err};
          else                 rec1 = '{1'b1, din_chan, LEN_W'(1), din, open_err};
        end
      end else if (state_q == BUSY) begin
        len_d = busy_len;
        sum_d = busy_sum;
        err_d = busy_err;
        if (din_eop) rec1 = '{1'b1, chan_q, busy_len, busy_sum, busy_err};
      end else if (din_eop) begin
        rec1 = '{1'b1, din_chan, '0, '0, 4'(1 << ERR_STRAY_EOP)};
      end
    end
  end

  // Output selection. A held record goes out first and displaces the new
  // one into the hold slot. The hold slot is only filled by a sop&eop beat
  // in BUSY, which leaves the FSM in IDLE where at most one record can be
  // produced, so the slot never overflows.
  always_comb begin
    if (pend_q.vld) begin
      take   = pend_q;
      pend_d = rec1;
    end else begin
      take   = rec1;
      pend_d = rec2;
    end
  end

  // Packet accumulators, hold slot and registered result record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_q <= '0;
      len_q  <= '0;
      sum_q  <= '0;
      err_q  <= '0;
      pend_q <= '0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      chan_q <= chan_d;
      len_q  <= len_d;
      sum_q  <= sum_d;
      err_q  <= err_d;
      pend_q <= pend_d;
      done_q <= take.vld;
      if (take.vld) out_q <= take;
    end
  end

  assign pkt_done = done_q;
  assign pkt_chan = out_q.chan;
  assign pkt_len  = out_q.len;
  assign pkt_sum  = out_q.sum;
  assign pkt_err  = out_q.err;

  logic [CNT_W-1:0] good_w [NUM_CHAN];
  logic [CNT_W-1:0] bad_w  [NUM_CHAN];

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_stat
    pkt_stat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (stat_clr),
      .inc_good_i (take.vld && take.chan == 2'(g) && take.err == '0),
      .inc_bad_i  (take.vld && take.chan == 2'(g) && take.err != '0),
      .good_o     (good_w[g]),
      .bad_o      (bad_w[g])
    );
  end

  // Statistics read mux; the unused channel code reads as zero.
  always_comb begin
    stat_good = '0;
    stat_bad  = '0;
    case (stat_sel)
      2'd0: begin stat_good = good_w[0]; stat_bad = bad_w[0]; end
      2'd1: begin stat_good = good_w[1]; stat_bad = bad_w[1]; end
      2'd2: begin stat_good = good_w[2]; stat_bad = bad_w[2]; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pkt_chk.sv
// Directed bench for pkt_chk with hand-computed expected records.
module tb_pkt_chk;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        din_sop = 1'b0, din_eop = 1'b0, din_vld = 1'b0;
  logic [1:0]  din_chan = '0;
  logic        pkt_done;
  logic [1:0]  pkt_chan;
  logic [11:0] pkt_len;
  logic [15:0] pkt_sum;
  logic [3:0]  pkt_err;
  logic        stat_clr = 1'b0;
  logic [1:0]  stat_sel = '0;
  logic [15:0] stat_good, stat_bad;

  int total = 0;
  int bad   = 0;

  pkt_chk dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_sop(din_sop), .din_eop(din_eop),
    .din_vld(din_vld), .din_chan(din_chan), .pkt_done(pkt_done), .pkt_chan(pkt_chan),
    .pkt_len(pkt_len), .pkt_sum(pkt_sum), .pkt_err(pkt_err), .stat_clr(stat_clr),
    .stat_sel(stat_sel), .stat_good(stat_good), .stat_bad(stat_bad)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rec(input string tag, input int done, input int chan,
                           input int len, input int sum, input int err);
    check({tag, ".done"}, 32'(pkt_done), done);
    check({tag, ".chan"}, 32'(pkt_chan), chan);
    check({tag, ".len"},  32'(pkt_len),  len);
    check({tag, ".sum"},  32'(pkt_sum),  sum);
    check({tag, ".err"},  32'(pkt_err),  err);
  endtask

  task automatic check_stat(input string tag, input logic [1:0] sel, input int good, input int badc);
    stat_sel = sel;
    #1;
    check({tag, ".good"}, 32'(stat_good), good);
    check({tag, ".bad"},  32'(stat_bad),  badc);
  endtask

  // One clock with the given beat driven; returns #1 after the edge.
  task automatic beat(input logic [1:0] ch, input logic [15:0] d, input logic s, input logic e);
    din_vld = 1'b1; din_chan = ch; din = d; din_sop = s; din_eop = e;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #12 rst_n = 1'b1;
    idle(1);
    check_rec("reset", 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) check_stat("reset_stat", 2'(c), 0, 0);

    // Basic 4-beat packet on channel 1.
    beat(1, 16'h0001, 1, 0);
    beat(1, 16'h0002, 0, 0);
    beat(1, 16'h0003, 0, 0);
    check("no_early_done", 32'(pkt_done), 0);
    beat(1, 16'h0004, 0, 1);
    check_rec("c1_4beat", 1, 1, 4, 16'h000A, 0);
    check_stat("c1_stat", 1, 1, 0);
    idle(1);
    check_rec("hold", 0, 1, 4, 16'h000A, 0);

    // Single-beat packet then a 2-beat packet, channel 2.
    beat(2, 16'hFFFF, 1, 1);
    check_rec("single", 1, 2, 1, 16'hFFFF, 0);
    beat(2, 16'h0001, 1, 0);
    check("gap", 32'(pkt_done), 0);
    beat(2, 16'h0001, 0, 1);
    check_rec("two_beat", 1, 2, 2, 16'h0002, 0);
    check_stat("c2_stat", 2, 2, 0);

    // Missing eop: new sop aborts the open channel-0 packet.
    beat(0, 16'h0005, 1, 0);
    beat(0, 16'h0006, 0, 0);
    beat(0, 16'h0007, 1, 0);
    check_rec("miss_eop", 1, 0, 2, 16'h000B, 4'b0001);
    check_stat("miss_stat", 0, 0, 1);
    beat(0, 16'h0008, 0, 1);
    check_rec("after_miss", 1, 0, 2, 16'h000F, 0);
    check_stat("after_miss_stat", 0, 1, 1);

    // Missing eop where the aborting beat is itself a sop&eop packet:
    // the aborted record comes first, the single-beat one on the next cycle.
    beat(1, 16'h0003, 1, 0);
    beat(1, 16'h0004, 0, 0);
    beat(1, 16'h0009, 1, 1);
    check_rec("abort_old", 1, 1, 2, 16'h0007, 4'b0001);
    idle(1);
    check_rec("abort_new", 1, 1, 1, 16'h0009, 0);
    check_stat("abort_stat", 1, 2, 1);
    idle(1);
    check("abort_quiet", 32'(pkt_done), 0);

    // Stray eop in IDLE, then a silently dropped beat.
    beat(0, 16'h0055, 0, 1);
    check_rec("stray", 1, 0, 0, 0, 4'b0010);
    beat(1, 16'h0077, 0, 0);
    check_rec("dropped", 0, 0, 0, 0, 4'b0010);
    idle(1);
    check("dropped2", 32'(pkt_done), 0);
    check_stat("stray_stat", 0, 1, 2);

    // Overlength: MAX_LEN+1 beats of 1.
    for (int i = 0; i < 1025; i++) beat(0, 16'h0001, i == 0, i == 1024);
    check_rec("overlen", 1, 0, 1025, 16'h0401, 4'b0100);
    check_stat("overlen_stat", 0, 1, 3);

    // Channel change mid-packet.
    beat(2, 16'h0001, 1, 0);
    beat(1, 16'h0002, 0, 0);
    beat(2, 16'h0003, 0, 1);
    check_rec("chan_chg", 1, 2, 3, 16'h0006, 4'b1000);
    check_stat("chan_chg_stat", 2, 2, 1);

    // Illegal channel 3 at sop: flagged, no counter touched.
    beat(3, 16'h0010, 1, 1);
    check_rec("chan3", 1, 3, 1, 16'h0010, 4'b1000);
    check_stat("chan3_sel", 3, 0, 0);
    check_stat("chan3_c2", 2, 2, 1);

    // Clear coincident with a counted packet: the update is lost.
    stat_clr = 1'b1;
    beat(1, 16'h0001, 1, 1);
    stat_clr = 1'b0;
    check_rec("clr_rec", 1, 1, 1, 16'h0001, 0);
    for (int c = 0; c < 3; c++) check_stat("clr_stat", 2'(c), 0, 0);

    // Reset mid-packet.
    beat(0, 16'h0001, 1, 0);
    beat(0, 16'h0002, 0, 0);
    din_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_rec("rst_async", 0, 0, 0, 0, 0);
    idle(2);
    #3 rst_n = 1'b1;
    idle(2);
    check_rec("rst_after", 0, 0, 0, 0, 0);
    beat(2, 16'h0010, 1, 0);
    beat(2, 16'h0020, 0, 1);
    check_rec("post_rst", 1, 2, 2, 16'h0030, 0);
    check_stat("post_rst_stat", 2, 1, 0);
    check_stat("post_rst_c0", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_chk.md
Name: pkt_chk

Overview:
- Sits on the clk domain directly downstream of the 3-channel packet merger.
- Consumes its merged stream: data, sop, eop, vld and 2-bit channel tag.
- Checks packet framing, measures length and a 16-bit modular sum per packet, and emits one result record per packet.
- Keeps per-channel good/error packet counters, readable through a select port.

Parameters:
- DATA_W, 16, data beat width.
- LEN_W, 12, packet length counter width (beats).
- MAX_LEN, 1024, maximum legal packet length in beats.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DATA_W  merged packet data.
- din_sop  in  1  start of packet, qualified by din_vld.
- din_eop  in  1  end of packet, qualified by din_vld.
- din_vld  in  1  beat valid.
- din_chan  in  2  source channel 0..2; 3 is illegal.
- pkt_done  out  1  one-cycle pulse: a result record is valid.
- pkt_chan  out  2  channel of the reported packet.
- pkt_len  out  LEN_W  beats in the packet, saturating at all-ones.
- pkt_sum  out  DATA_W  modulo-2^DATA_W sum of all beats.
- pkt_err  out  4  [0] missing eop, [1] stray eop, [2] overlength, [3] channel error.
- stat_clr  in  1  synchronous clear of all statistics counters.
- stat_sel  in  2  channel whose counters are presented.
- stat_good  out  CNT_W  good-packet count of stat_sel.
- stat_bad  out  CNT_W  errored-packet count of stat_sel.

Behaviour:
- Reset, asynchronous: state IDLE; pkt_done, pkt_chan, pkt_len, pkt_sum and pkt_err all 0; all counters 0.
- pkt_* outputs are registered and hold their last record between pulses.
- stat_good and stat_bad are a combinational mux of registers; stat_sel=3 returns 0.
- FSM has two states, IDLE and BUSY. Inputs are ignored when din_vld=0.
- IDLE, vld&sop: capture chan, len=1, sum=din, err=0.
  - If eop is also set (single-beat packet), report next cycle and stay in IDLE.
  - Otherwise go to BUSY.
- IDLE, vld&!sop&!eop: beat dropped silently.
- IDLE, vld&!sop&eop: report next cycle with len=0, sum=0, chan=din_chan, err=0010.
- BUSY, vld&!sop: len+1 (saturating), sum+=din.
  - If the new len exceeds MAX_LEN, set err[2] (sticky).
  - If din_chan differs from the captured chan, set err[3] (sticky).
  - If eop: report next cycle, go to IDLE.
- BUSY, vld&sop: report the old packet next cycle with err[0] set.
  - This beat opens a new packet in the same cycle (IDLE&sop rules apply, including sop&eop).
- err[3] is also set at sop when din_chan=3.
- Latency: pkt_done asserts exactly 1 cycle after the terminating beat. Back-to-back packets give consecutive pulses.
- Statistics update on the same edge that raises pkt_done, so they are visible the cycle of the pulse.
  - err==0 increments good[chan]; otherwise bad[chan] increments.
  - chan=3 updates nothing.
  - Counters saturate at all-ones.
  - stat_clr has priority over a coincident update; that update is lost.
- Reset mid-packet: the partial packet is discarded, with no record and no count.

Decomposition:
- Shared package pkt_pkg holds:
  - constants ERR_MISS_EOP=0, ERR_STRAY_EOP=1, ERR_OVERLEN=2, ERR_CHAN=3;
  - NUM_CHAN=3;
  - state encodings IDLE/BUSY.
- One natural sub-module: pkt_stat_cnt, a per-channel saturating good/bad counter pair with clear, instantiated 3 times.

Test Plan:
- Chan 1 packet of 4 beats, data 0x0001..0x0004, sop on beat 1 and eop on beat 4 → one cycle after eop: pkt_done=1, chan=1, len=4, sum=0x000A, err=0; stat_sel=1 gives good=1.
- Single beat sop&eop, chan 2, data 0xFFFF, followed immediately by a 2-beat chan-2 packet of 0x0001,0x0001 → consecutive pulses: (len=1, sum=0xFFFF) then (len=2, sum=0x0002); good[2]=2.
- Chan 0 packet sop, 2 beats, then a new sop without eop → record len=2, err=0001, bad[0]=1; the new packet then completes normally.
- Lone vld&eop in IDLE on chan 0 → record len=0, err=0010; a lone non-eop beat in IDLE gives no record.
- Chan 0 packet of MAX_LEN+1 beats → err=0100, len=1025. A separate packet whose chan changes mid-packet → err=1000. stat_clr asserted on its pulse cycle → counters read 0.
- Assert rst_n low mid-packet, then release → no pulse and all outputs 0; the next clean packet is reported correctly.
